ram_bus_master: RTL and testbench
=================================

Name: ram_bus_master

Overview:
- Initiator side of the RAM chip-select/write-enable bus: csRAM, weRAM, 12-bit address, 4-bit bidirectional data.
- Accepts single read/write requests from the core over a valid/ready handshake.
- Sequences the RAM bus cycle by cycle, owns the tristate data driver and enforces bus turnaround.
- Returns read data with a one-cycle response pulse; sits between the fetch/execute logic and the RAM.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 4, RAM data width (nibble).
- WAIT_CYCLES, 1, read access cycles with csRAM=1, weRAM=0 before data is sampled; legal range 1..15.
- TURN_CYCLES, 1, idle cycles after a write with the bus released before the next request is accepted; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  master can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read; sampled on accept.
- req_addr  in  ADDR_W  request address; sampled on accept.
- req_wdata  in  DATA_W  write data; sampled on accept.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  out  DATA_W  last read data; held until the next read completes.
- busy  out  1  high in any state other than IDLE.
- csRAM  out  1  RAM chip select.
- weRAM  out  1  RAM write enable.
- address  out  ADDR_W  RAM address.
- data  inout  DATA_W  RAM data bus; driven only during a write cycle, otherwise high-Z.

Behaviour:
- Reset (async, immediate on assertion, including mid-cycle):
  - state=IDLE; csRAM=0, weRAM=0, address=0, data=Z.
  - rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0 while reset is high.
  - Any in-flight access is aborted. No response is produced for it.
- States: IDLE, WRITE, READ, TURN.
- IDLE:
  - req_ready=1, csRAM=0, weRAM=0, data=Z, address holds its last value.
  - Accept = req_valid & req_ready at a rising edge. Latch req_we, req_addr and req_wdata.
  - Next state is WRITE if req_we=1, otherwise READ.
- WRITE (exactly 1 cycle):
  - csRAM=1, weRAM=1, address=latched address, data=latched wdata.
  - Next state is TURN if TURN_CYCLES>0, otherwise IDLE.
  - No response pulse is produced for writes.
- TURN (TURN_CYCLES cycles):
  - csRAM=0, weRAM=0, data=Z, address held, req_ready=0.
  - Next state is IDLE when the counter expires.
- READ (WAIT_CYCLES cycles):
  - csRAM=1, weRAM=0, address=latched address, data=Z.
  - data is sampled into rsp_rdata on the rising edge that ends the last READ cycle.
  - The next cycle is IDLE with rsp_valid=1 for exactly one cycle; req_ready=1 in that same cycle, so back-to-back reads are allowed.
- Latency:
  - Read: accept at edge N; rsp_valid high in the cycle after edge N+WAIT_CYCLES. With defaults, the response arrives 2 cycles after accept.
  - Write: the bus write occupies the cycle after accept; the next accept is possible TURN_CYCLES+1 cycles after that.
- Bus-safety invariants (hold in every cycle):
  - data is driven if and only if weRAM=1.
  - weRAM=1 implies csRAM=1.
  - csRAM, weRAM and address are glitch-free registered outputs; the data driver enable is derived from the same register as weRAM.
- Counter: a single 4-bit down-counter shared by READ and TURN, loaded on state entry. A parameter value of 0 for TURN_CYCLES bypasses that state entirely.
- req_valid held high while busy has no effect; a request is accepted only in IDLE. Inputs changing while not in IDLE are ignored because the latched copy is used.
- Requests are serviced strictly in order; there is no read-after-write forwarding.

Test Plan:
- Write then readback: write 0x000=0011, 0x001=1100, 0x002=0110, then read 0x000/0x001/0x002 -> rsp_rdata 0011, 1100, 0110, each with a single rsp_valid pulse 2 cycles after accept.
- Turnaround with TURN_CYCLES=1: write 0x005=1010 with req_valid held high for a following read of 0x005 -> req_ready=0 for 2 cycles after accept; data=Z, csRAM=0 in the TURN cycle; the read returns 1010.
- Back-to-back reads at 0x7FF and 0xFFF with req_valid held continuously -> accepts every 2 cycles; rsp_valid is asserted in the same cycle as the next accept; address steps 7FF->FFF.
- Bus safety: a checker runs for the whole test -> data never driven while weRAM=0; weRAM never 1 with csRAM=0; zero violations.
- Reset mid-read: assert reset during the READ cycle of a read of 0x003 -> csRAM=0, weRAM=0, data=Z immediately (before the next edge); no rsp_valid pulse; after release, req_ready=1 and a new read of 0x003 completes normally.
- Parameter sweep WAIT_CYCLES=3, TURN_CYCLES=0 -> the read response arrives 4 cycles after accept; a write is followed by accept on the very next IDLE cycle.

Source files
------------

// File: rtl/ram_bus_master.sv
// ram_bus_master: initiator for the csRAM/weRAM nibble RAM bus.
// Accepts single read/write requests on a valid/ready handshake, sequences
// the bus cycle by cycle, owns the tristate data driver and enforces the
// post-write turnaround before the next request is taken.
module ram_bus_master #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned WAIT_CYCLES = 1,   // 1..15
  parameter int unsigned TURN_CYCLES = 1    // 0..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              csRAM,
  output logic              weRAM,
  output logic [ADDR_W-1:0] address,
  inout  logic [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  // Counter preload values: the counter expires at zero, so load N-1.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] wdata_q;

  // Bus sequencer: state, shared down-counter and all registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      csRAM     <= 1'b0;
      weRAM     <= 1'b0;
      address   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // req_ready is high whenever IDLE and out of reset, so valid alone accepts
          if (req_valid) begin
            address <= req_addr;
            wdata_q <= req_wdata;
            csRAM   <= 1'b1;
            if (req_we) begin
              weRAM <= 1'b1;
              state <= WRITE;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= READ;
            end
          end
        end
        WRITE: begin
          csRAM <= 1'b0;
          weRAM <= 1'b0;
          if (TURN_CYCLES > 0) begin
            cnt   <= TURN_LOAD;
            state <= TURN;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (cnt == '0) begin
            rsp_rdata <= data;
            rsp_valid <= 1'b1;
            csRAM     <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake/status decode; ready is forced low while reset is asserted.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    busy      = (state != IDLE);
  end

  // Data driver enable is the weRAM register itself, so drive tracks weRAM exactly.
  assign data = weRAM ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: a default instance (WAIT=1, TURN=1)
// and a swept instance (WAIT=3, TURN=0), each with a behavioural RAM.
module tb_ram_bus_master;
  localparam int AW     = 12;
  localparam int DW     = 4;
  localparam int A_WAIT = 1;
  localparam int A_TURN = 1;
  localparam int B_WAIT = 3;
  localparam int B_TURN = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- instance A (defaults) ----------------
  logic          a_valid, a_ready, a_we, a_rsp_valid, a_busy, a_cs, a_wen;
  logic [AW-1:0] a_addr, a_address;
  logic [DW-1:0] a_wdata, a_rdata, a_drive;
  wire  [DW-1:0] a_data;
  logic [DW-1:0] a_mem [4096] = '{default: '0};
  logic [DW-1:0] a_exp [4096] = '{default: '0};

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(A_WAIT), .TURN_CYCLES(A_TURN)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .busy(a_busy), .csRAM(a_cs), .weRAM(a_wen), .address(a_address), .data(a_data));

  // RAM A: stores on write cycles, drives read data when selected, else drives zero
  always @(posedge clk) if (a_cs && a_wen) a_mem[a_address] <= a_data;
  always_comb a_drive = a_cs ? a_mem[a_address] : '0;
  assign a_data = a_wen ? 'z : a_drive;

  // ---------------- instance B (WAIT=3, TURN=0) ----------------
  logic          b_valid, b_ready, b_we, b_rsp_valid, b_busy, b_cs, b_wen;
  logic [AW-1:0] b_addr, b_address;
  logic [DW-1:0] b_wdata, b_rdata, b_drive;
  wire  [DW-1:0] b_data;
  logic [DW-1:0] b_mem [4096] = '{default: '0};
  logic [DW-1:0] b_exp [4096] = '{default: '0};

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(B_WAIT), .TURN_CYCLES(B_TURN)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .busy(b_busy), .csRAM(b_cs), .weRAM(b_wen), .address(b_address), .data(b_data));

  always @(posedge clk) if (b_cs && b_wen) b_mem[b_address] <= b_data;
  always_comb b_drive = b_cs ? b_mem[b_address] : '0;
  assign b_data = b_wen ? 'z : b_drive;

  // Bus-safety checker: weRAM implies csRAM; with weRAM low the DUT must not drive
  // (any DUT drive would corrupt the value the RAM model puts on the bus).
  always @(negedge clk) begin
    n_total++;
    if ((a_wen && !a_cs) || (!a_wen && a_data !== a_drive))
      $display("FAIL bus_safety_a cs=%b we=%b data=%h required_data=%h", a_cs, a_wen, a_data, a_drive);
    else n_pass++;
    n_total++;
    if ((b_wen && !b_cs) || (!b_wen && b_data !== b_drive))
      $display("FAIL bus_safety_b cs=%b we=%b data=%h required_data=%h", b_cs, b_wen, b_data, b_drive);
    else n_pass++;
  end

  // Present a request on A from a negedge; returns at the negedge after the accept edge.
  task automatic a_issue(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         output int acc, output bit ok);
    a_valid = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    ok = 1'b0; acc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (a_ready) begin
        @(posedge clk); #1 acc = cyc; ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic b_issue(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         output int acc, output bit ok);
    b_valid = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    ok = 1'b0; acc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (b_ready) begin
        @(posedge clk); #1 acc = cyc; ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // Watch rsp_valid over a window of negedges; report first pulse cycle and pulse count.
  task automatic a_wait_rsp(input int len, output int rc, output int pulses);
    rc = -1; pulses = 0;
    for (int i = 0; i < len; i++) begin
      if (a_rsp_valid) begin pulses++; if (rc < 0) rc = cyc; end
      @(negedge clk);
    end
  endtask

  task automatic b_wait_rsp(input int len, output int rc, output int pulses);
    rc = -1; pulses = 0;
    for (int i = 0; i < len; i++) begin
      if (b_rsp_valid) begin pulses++; if (rc < 0) rc = cyc; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (a_ready !== 1'b0 || a_busy !== 1'b0) $display("FAIL reset_a_ready_busy got %b%b required 00", a_ready, a_busy); else n_pass++;
    n_total++; if (a_cs !== 1'b0 || a_wen !== 1'b0) $display("FAIL reset_a_cs_we got %b%b required 00", a_cs, a_wen); else n_pass++;
    n_total++; if (a_address !== '0) $display("FAIL reset_a_address got %h required 000", a_address); else n_pass++;
    n_total++; if (a_rsp_valid !== 1'b0 || a_rdata !== '0) $display("FAIL reset_a_rsp got %b/%h required 0/0", a_rsp_valid, a_rdata); else n_pass++;
    n_total++; if (a_data !== '0) $display("FAIL reset_a_data got %h required undriven(0)", a_data); else n_pass++;
    n_total++; if (b_ready !== 1'b0 || b_cs !== 1'b0 || b_wen !== 1'b0) $display("FAIL reset_b got rdy=%b cs=%b we=%b required 000", b_ready, b_cs, b_wen); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL reset_release_ready got %b%b required 11", a_ready, b_ready); else n_pass++;
  endtask

  task automatic test_write_readback();
    logic [AW-1:0] ad [3] = '{12'h000, 12'h001, 12'h002};
    logic [DW-1:0] wd [3] = '{4'b0011, 4'b1100, 4'b0110};
    int acc, rc, pulses; bit ok;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a_issue(1'b1, ad[i], wd[i], acc, ok); a_valid = 1'b0;
      n_total++; if (!ok) $display("FAIL wr_accept_timeout addr=%h", ad[i]); else n_pass++;
      n_total++;
      if (a_cs !== 1'b1 || a_wen !== 1'b1 || a_address !== ad[i] || a_data !== wd[i] || a_ready !== 1'b0 || a_busy !== 1'b1)
        $display("FAIL wr_cycle got cs=%b we=%b addr=%h data=%h rdy=%b busy=%b required 1 1 %h %h 0 1",
                 a_cs, a_wen, a_address, a_data, a_ready, a_busy, ad[i], wd[i]);
      else n_pass++;
      a_exp[ad[i]] = wd[i];
    end
    for (int i = 0; i < 3; i++) begin
      a_issue(1'b0, ad[i], '0, acc, ok); a_valid = 1'b0;
      a_wait_rsp(A_WAIT + 4, rc, pulses);
      n_total++; if (!ok || rc - acc != A_WAIT || pulses != 1) $display("FAIL rd_latency got delta=%0d pulses=%0d required %0d/1", rc - acc, pulses, A_WAIT); else n_pass++;
      n_total++; if (a_rdata !== a_exp[ad[i]]) $display("FAIL rd_data addr=%h got %b required %b", ad[i], a_rdata, a_exp[ad[i]]); else n_pass++;
    end
  endtask

  task automatic test_turnaround();
    int acc, acc2, rc, pulses; bit ok;
    @(negedge clk);
    a_issue(1'b1, 12'h005, 4'b1010, acc, ok);
    a_exp[5] = 4'b1010;
    a_we = 1'b0;  // valid held high, now presenting the read of the same address
    n_total++; if (!ok || a_ready !== 1'b0) $display("FAIL turn_ready_write got %b required 0", a_ready); else n_pass++;
    @(negedge clk);
    n_total++;
    if (a_ready !== 1'b0 || a_cs !== 1'b0 || a_wen !== 1'b0 || a_data !== '0)
      $display("FAIL turn_cycle got rdy=%b cs=%b we=%b data=%h required 0 0 0 undriven", a_ready, a_cs, a_wen, a_data);
    else n_pass++;
    @(negedge clk);
    a_issue(1'b0, 12'h005, '0, acc2, ok); a_valid = 1'b0;
    n_total++; if (!ok || acc2 - acc != A_TURN + 2) $display("FAIL turn_next_accept got delta=%0d required %0d", acc2 - acc, A_TURN + 2); else n_pass++;
    a_wait_rsp(A_WAIT + 4, rc, pulses);
    n_total++; if (rc - acc2 != A_WAIT || pulses != 1 || a_rdata !== 4'b1010) $display("FAIL turn_readback got delta=%0d pulses=%0d data=%b required %0d/1/1010", rc - acc2, pulses, a_rdata, A_WAIT); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, acc1; bit ok;
    logic [DW-1:0] v1, v2;
    v1 = DW'($urandom_range(1, 15)); v2 = DW'($urandom_range(1, 15));
    @(negedge clk);
    a_issue(1'b1, 12'h7FF, v1, acc, ok); a_exp[12'h7FF] = v1;
    a_issue(1'b1, 12'hFFF, v2, acc, ok); a_exp[12'hFFF] = v2;
    a_issue(1'b0, 12'h7FF, '0, acc1, ok);
    n_total++; if (!ok || a_address !== 12'h7FF || a_cs !== 1'b1 || a_wen !== 1'b0) $display("FAIL b2b_first got addr=%h cs=%b we=%b required 7ff 1 0", a_address, a_cs, a_wen); else n_pass++;
    a_addr = 12'hFFF;  // next read queued with valid held
    @(negedge clk);
    n_total++;
    if (a_rsp_valid !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_rdata !== a_exp[12'h7FF])
      $display("FAIL b2b_rsp1 got v=%b rdy=%b busy=%b data=%h required 1 1 0 %h", a_rsp_valid, a_ready, a_busy, a_rdata, a_exp[12'h7FF]);
    else n_pass++;
    @(negedge clk);
    a_valid = 1'b0;
    n_total++; if (a_address !== 12'hFFF || a_cs !== 1'b1 || cyc - acc1 != 2) $display("FAIL b2b_second_accept got addr=%h cs=%b delta=%0d required fff 1 2", a_address, a_cs, cyc - acc1); else n_pass++;
    @(negedge clk);
    n_total++; if (a_rsp_valid !== 1'b1 || a_rdata !== a_exp[12'hFFF]) $display("FAIL b2b_rsp2 got v=%b data=%h required 1 %h", a_rsp_valid, a_rdata, a_exp[12'hFFF]); else n_pass++;
    @(negedge clk);
    n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL b2b_single_pulse got %b required 0", a_rsp_valid); else n_pass++;
  endtask

  task automatic test_random();
    int acc, rc, pulses; bit ok;
    logic we; logic [AW-1:0] ad; logic [DW-1:0] wd;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1)); ad = AW'($urandom_range(0, 15)); wd = DW'($urandom);
      a_issue(we, ad, wd, acc, ok); a_valid = 1'b0;
      if (we) begin
        n_total++; if (!ok || a_wen !== 1'b1 || a_address !== ad || a_data !== wd) $display("FAIL rand_write got we=%b addr=%h data=%h required 1 %h %h", a_wen, a_address, a_data, ad, wd); else n_pass++;
        a_exp[ad] = wd;
      end else begin
        a_wait_rsp(A_WAIT + 3, rc, pulses);
        n_total++; if (!ok || rc - acc != A_WAIT || pulses != 1 || a_rdata !== a_exp[ad]) $display("FAIL rand_read addr=%h got delta=%0d pulses=%0d data=%h required %0d/1/%h", ad, rc - acc, pulses, a_rdata, A_WAIT, a_exp[ad]); else n_pass++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_midread();
    int acc, rc, pulses; bit ok;
    @(negedge clk);
    a_issue(1'b1, 12'h003, 4'b1001, acc, ok); a_exp[3] = 4'b1001;
    a_issue(1'b0, 12'h003, '0, acc, ok); a_valid = 1'b0;
    n_total++; if (!ok || a_cs !== 1'b1 || a_wen !== 1'b0) $display("FAIL midrd_in_read got cs=%b we=%b required 1 0", a_cs, a_wen); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (a_cs !== 1'b0 || a_wen !== 1'b0 || a_data !== '0 || a_busy !== 1'b0 || a_ready !== 1'b0)
      $display("FAIL midrd_async got cs=%b we=%b data=%h busy=%b rdy=%b required 0 0 undriven 0 0", a_cs, a_wen, a_data, a_busy, a_ready);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_rsp_valid) pulses++;
    end
    reset = 1'b0;
    #1;
    n_total++; if (pulses != 0 || a_rsp_valid !== 1'b0) $display("FAIL midrd_no_rsp got %0d pulses required 0", pulses); else n_pass++;
    n_total++; if (a_ready !== 1'b1 || a_rdata !== '0) $display("FAIL midrd_release got rdy=%b rdata=%h required 1 0", a_ready, a_rdata); else n_pass++;
    @(negedge clk);
    a_issue(1'b0, 12'h003, '0, acc, ok); a_valid = 1'b0;
    a_wait_rsp(A_WAIT + 4, rc, pulses);
    n_total++; if (!ok || rc - acc != A_WAIT || pulses != 1 || a_rdata !== 4'b1001) $display("FAIL midrd_reread got delta=%0d pulses=%0d data=%b required %0d/1/1001", rc - acc, pulses, a_rdata, A_WAIT); else n_pass++;
  endtask

  task automatic test_param_sweep();
    int acc, acc2, rc, pulses; bit ok;
    logic [AW-1:0] ad; logic [DW-1:0] wd;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      ad = AW'($urandom_range(0, 4095)); wd = DW'($urandom_range(1, 15));
      b_issue(1'b1, ad, wd, acc, ok);
      n_total++; if (!ok || b_wen !== 1'b1 || b_address !== ad || b_data !== wd) $display("FAIL sweep_write got we=%b addr=%h data=%h required 1 %h %h", b_wen, b_address, b_data, ad, wd); else n_pass++;
      b_exp[ad] = wd;
      b_we = 1'b0;  // valid held: read back as soon as the master is idle again
      b_issue(1'b0, ad, '0, acc2, ok); b_valid = 1'b0;
      n_total++; if (!ok || acc2 - acc != B_TURN + 2) $display("FAIL sweep_next_accept got delta=%0d required %0d", acc2 - acc, B_TURN + 2); else n_pass++;
      b_wait_rsp(B_WAIT + 3, rc, pulses);
      n_total++; if (rc - acc2 != B_WAIT || pulses != 1 || b_rdata !== b_exp[ad]) $display("FAIL sweep_read got delta=%0d pulses=%0d data=%h required %0d/1/%h", rc - acc2, pulses, b_rdata, B_WAIT, b_exp[ad]); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_readback();
    test_turnaround();
    test_back_to_back();
    test_random();
    test_reset_midread();
    test_param_sweep();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
